// File: rtl/dht11_reader_pkg.sv
// Shared definitions for the DHT11 single-wire reader: FSM encoding, frame layout,
// default timings and the frame checksum helper.
package dht11_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_LOW = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RESP_LOW  = 3'd3,
    ST_RESP_HIGH = 3'd4,
    ST_BIT_LOW   = 3'd5,
    ST_BIT_HIGH  = 3'd6,
    ST_CHECK     = 3'd7
  } state_t;

  localparam int FRAME_BITS = 40;
  localparam int RH_INT_LSB = 32;
  localparam int RH_DEC_LSB = 24;
  localparam int T_INT_LSB  = 16;
  localparam int T_DEC_LSB  = 8;
  localparam int CSUM_LSB   = 0;

  localparam int DEF_CLK_HZ         = 25_000_000;
  localparam int DEF_READ_PERIOD_MS = 2000;
  localparam int DEF_START_LOW_US   = 18000;
  localparam int DEF_TIMEOUT_US     = 100;
  localparam int DEF_BIT_THRESH_US  = 40;

  // Sum of the four data bytes in a 10-bit accumulator; only the low byte is compared.
  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [9:0] sum;
    sum = 10'(frame[RH_INT_LSB +: 8]) + 10'(frame[RH_DEC_LSB +: 8])
        + 10'(frame[T_INT_LSB +: 8]) + 10'(frame[T_DEC_LSB +: 8]);
    return sum[7:0] == frame[CSUM_LSB +: 8];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: one-cycle us_tick every CLK_HZ/1e6 hclk cycles.
module dht11_us_tick #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic hclk,
  input  logic rst_n,
  output logic us_tick
);

  localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      cnt     <= '0;
      us_tick <= 1'b0;
    end else begin
      us_tick <= (cnt == LAST);
      cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 host controller: periodic read transaction, 40-bit frame decode and checksum,
// holding the last good humidity/temperature bytes.
module dht11_reader
  import dht11_reader_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int READ_PERIOD_MS = DEF_READ_PERIOD_MS,
  parameter int START_LOW_US   = DEF_START_LOW_US,
  parameter int TIMEOUT_US     = DEF_TIMEOUT_US,
  parameter int BIT_THRESH_US  = DEF_BIT_THRESH_US
) (
  input  logic       hclk,
  input  logic       rst_n,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       chk_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam logic [14:0] START_LAST  = 15'(START_LOW_US - 1);
  localparam logic [14:0] TIMEOUT_LIM = 15'(TIMEOUT_US);
  localparam logic [14:0] THRESH      = 15'(BIT_THRESH_US);
  localparam logic [11:0] PERIOD      = 12'(READ_PERIOD_MS);
  localparam logic [11:0] PERIOD_M1   = 12'(READ_PERIOD_MS - 1);
  localparam logic [9:0]  MS_LAST     = 10'd999;

  logic                  sync1, sync2, line_q;
  logic                  rise, fall;
  logic                  us_tick, ms_tick, start, timed_out;
  state_t                state, state_n;
  logic [14:0]           us_cnt, hi_us;
  logic [9:0]            us_div;
  logic [11:0]           period_cnt;
  logic [5:0]            bit_idx;
  logic [FRAME_BITS-1:0] shift;

  dht11_us_tick #(.CLK_HZ(CLK_HZ)) u_us_tick (
    .hclk    (hclk),
    .rst_n   (rst_n),
    .us_tick (us_tick)
  );

  assign rise    = sync2 & ~line_q;
  assign fall    = ~sync2 & line_q;
  assign ms_tick = us_tick && (us_div == MS_LAST);
  // The ms tick that completes the period starts the next read with no extra cycle.
  assign start   = (state == ST_IDLE) &&
                   ((period_cnt == PERIOD) || (ms_tick && (period_cnt == PERIOD_M1)));
  // High time includes the tick of the cycle that sees the falling edge.
  assign hi_us   = us_cnt + 15'(us_tick);

  always_comb begin
    state_n   = state;
    timed_out = 1'b0;
    case (state)
      ST_IDLE:      state_n = start ? ST_START_LOW : ST_IDLE;
      ST_START_LOW: state_n = (us_tick && (us_cnt == START_LAST)) ? ST_RELEASE : ST_START_LOW;
      ST_RELEASE:   state_n = fall ? ST_RESP_LOW : ST_RELEASE;
      ST_RESP_LOW:  state_n = rise ? ST_RESP_HIGH : ST_RESP_LOW;
      ST_RESP_HIGH: state_n = fall ? ST_BIT_LOW : ST_RESP_HIGH;
      ST_BIT_LOW:   state_n = rise ? ST_BIT_HIGH : ST_BIT_LOW;
      ST_BIT_HIGH:  state_n = fall ? ((bit_idx == 6'd39) ? ST_CHECK : ST_BIT_LOW) : ST_BIT_HIGH;
      ST_CHECK:     state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
    if ((state inside {ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH}) &&
        (state_n == state) && us_tick && (us_cnt == TIMEOUT_LIM)) begin
      state_n   = ST_IDLE;
      timed_out = 1'b1;
    end else begin
      timed_out = 1'b0;
    end
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      line_q     <= 1'b1;
      state      <= ST_IDLE;
      us_cnt     <= 15'd0;
      us_div     <= 10'd0;
      period_cnt <= 12'd0;
    end else begin
      sync1  <= dht_in;
      sync2  <= sync1;
      line_q <= sync2;
      state  <= state_n;
      us_cnt <= (state_n != state) ? 15'd0 : us_cnt + 15'(us_tick);
      if (start) begin
        us_div     <= 10'd0;
        period_cnt <= 12'd0;
      end else if (us_tick) begin
        us_div <= ms_tick ? 10'd0 : us_div + 10'd1;
        if (ms_tick && (period_cnt != PERIOD)) begin
          period_cnt <= period_cnt + 12'd1;
        end
      end
    end
  end

  // Frame capture and registered outputs.
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      bit_idx     <= 6'd0;
      shift       <= '0;
      dht_oe      <= 1'b0;
      busy        <= 1'b0;
      humidity    <= 8'd0;
      temperature <= 8'd0;
      data_valid  <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dht_oe      <= (state_n == ST_START_LOW);
      busy        <= (state_n != ST_IDLE);
      timeout_err <= timed_out;
      data_valid  <= 1'b0;
      chk_err     <= 1'b0;
      if ((state == ST_IDLE) && (state_n == ST_START_LOW)) begin
        shift <= '0;
      end else if ((state == ST_BIT_HIGH) && fall) begin
        shift <= {shift[FRAME_BITS-2:0], (hi_us > THRESH)};
      end
      if ((state == ST_RESP_HIGH) && fall) begin
        bit_idx <= 6'd0;
      end else if ((state == ST_BIT_HIGH) && fall) begin
        bit_idx <= bit_idx + 6'd1;
      end
      if (state == ST_CHECK) begin
        if (checksum_ok(shift)) begin
          humidity    <= shift[RH_INT_LSB +: 8];
          temperature <= shift[T_INT_LSB +: 8];
          data_valid  <= 1'b1;
        end else begin
          chk_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural DHT11 sensor on a wired-AND line, random bit
// timings, and a frame-level reference model decoding from the driven high times.
`timescale 1ns/1ps
module tb_dht11_reader;

  localparam int PERIOD_MS = 7;
  localparam int START_US  = 500;
  localparam int PERIOD_CY = PERIOD_MS * 1000;

  logic       hclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_low = 1'b0;
  logic       dht_in, dht_oe, data_valid, chk_err, timeout_err, busy;
  logic [7:0] humidity, temperature;

  assign dht_in = ~(dht_oe | sensor_low);

  dht11_reader #(
    .CLK_HZ(1_000_000), .READ_PERIOD_MS(PERIOD_MS), .START_LOW_US(START_US),
    .TIMEOUT_US(100), .BIT_THRESH_US(40)
  ) dut (
    .hclk(hclk), .rst_n(rst_n), .dht_in(dht_in), .dht_oe(dht_oe),
    .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
    .chk_err(chk_err), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int n_dv = 0, n_chk = 0, n_to = 0;
  int dv_last = 0, dv_prev = 0, to_cyc = 0;
  int oe_rise = 0, oe_rise_prev = 0, oe_fall = 0;
  logic oe_q = 1'b0;
  int hi_us[40];
  int cur_bit = -1;
  logic [7:0] exp_hum = 8'd0, exp_temp = 8'd0;

  always @(posedge hclk) cyc <= cyc + 1;

  always @(negedge hclk) begin
    if (data_valid) begin n_dv++; dv_prev = dv_last; dv_last = cyc; end
    if (chk_err) n_chk++;
    if (timeout_err) begin n_to++; to_cyc = cyc; end
    if (dht_oe && !oe_q) begin oe_rise_prev = oe_rise; oe_rise = cyc; end
    if (!dht_oe && oe_q) oe_fall = cyc;
    oe_q = dht_oe;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Random high times that encode the given frame, MSB first.
  task automatic gen_hi(input logic [39:0] frame);
    for (int i = 0; i < 40; i++)
      hi_us[i] = frame[39-i] ? int'($urandom_range(75, 45)) : int'($urandom_range(35, 18));
  endtask

  // Sensor: wait for the host start pulse, then answer with the hi_us bit train.
  task automatic send_frame(input bit silent, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!dht_oe && n < 20000) begin @(negedge hclk); n++; end
    while (dht_oe && n < 20000) begin @(negedge hclk); n++; end
    if (n >= 20000) return;
    ok = 1'b1;
    if (silent) return;
    repeat (20) @(negedge hclk);
    sensor_low = 1'b1; repeat (80) @(negedge hclk);
    sensor_low = 1'b0; repeat (80) @(negedge hclk);
    for (int i = 0; i < 40; i++) begin
      cur_bit = i;
      sensor_low = 1'b1; repeat (50) @(negedge hclk);
      sensor_low = 1'b0; repeat (hi_us[i]) @(negedge hclk);
    end
    sensor_low = 1'b1; repeat (50) @(negedge hclk);
    sensor_low = 1'b0;
    cur_bit = 40;
  endtask

  // Reference: decode by threshold, verify byte checksum, update expected outputs.
  task automatic run_txn(input string tag, input bit chk_period);
    int dv0 = n_dv, chk0 = n_chk, to0 = n_to;
    int b[5];
    bit ok, good;
    send_frame(1'b0, ok);
    check({tag, "_start"}, ok, 1);
    repeat (10) @(negedge hclk);
    for (int k = 0; k < 5; k++) begin
      b[k] = 0;
      for (int j = 0; j < 8; j++) b[k] = b[k] * 2 + ((hi_us[k*8+j] > 40) ? 1 : 0);
    end
    good = ((b[0] + b[1] + b[2] + b[3]) % 256) == b[4];
    if (good) begin exp_hum = 8'(b[0]); exp_temp = 8'(b[2]); end
    check({tag, "_dv"}, n_dv - dv0, good ? 1 : 0);
    check({tag, "_chk"}, n_chk - chk0, good ? 0 : 1);
    check({tag, "_to"}, n_to - to0, 0);
    check({tag, "_hum"}, humidity, exp_hum);
    check({tag, "_temp"}, temperature, exp_temp);
    check({tag, "_oe_len"}, oe_fall - oe_rise, START_US);
    check({tag, "_busy"}, busy, 0);
    if (chk_period) check({tag, "_period"}, oe_rise - oe_rise_prev, PERIOD_CY);
  endtask

  initial begin
    logic [39:0] fr;
    logic [7:0] h, t;
    int to0, chk0, dv0, n;
    bit ok;

    repeat (3) @(negedge hclk);
    check("rst_oe", dht_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_hum", humidity, 0);
    check("rst_temp", temperature, 0);
    check("rst_pulses", {data_valid, chk_err, timeout_err}, 0);
    rst_n = 1'b1;

    // 1: known good frame
    gen_hi(40'h37_00_18_00_4F);
    run_txn("t1", 1'b0);
    check("t1_hum_lit", humidity, 8'd55);

    // 2: bad checksum, outputs hold
    gen_hi(40'h37_00_18_00_50);
    run_txn("t2", 1'b1);

    // 3: silent sensor -> timeout
    to0 = n_to; chk0 = n_chk; dv0 = n_dv;
    send_frame(1'b1, ok);
    check("t3_start", ok, 1);
    n = 0;
    while (n_to == to0 && n < 300) begin @(negedge hclk); n++; end
    check("t3_to_cnt", n_to - to0, 1);
    check("t3_to_delay", to_cyc - oe_fall, 101);
    check("t3_oe", dht_oe, 0);
    check("t3_other", (n_chk - chk0) + (n_dv - dv0), 0);
    check("t3_hum", humidity, exp_hum);
    check("t3_period", oe_rise - oe_rise_prev, PERIOD_CY);

    // 4: threshold boundaries 27/70/40/41 inside a random valid frame
    h = {2'b10, 6'($urandom_range(63, 0))};
    t = {2'b01, 6'($urandom_range(63, 0))};
    fr = {h, 8'd0, t, 8'd0, 8'(h + t)};
    gen_hi(fr);
    hi_us[0] = 41; hi_us[1] = 40; hi_us[16] = 27; hi_us[17] = 70;
    run_txn("t4", 1'b1);
    check("t4_hum_lit", humidity, h);

    // 5: reset during bit 20, then a good frame
    h = 8'($urandom_range(95, 5)); t = 8'($urandom_range(50, 0));
    gen_hi({h, 8'd0, t, 8'd0, 8'(h + t)});
    cur_bit = -1;
    to0 = n_to; chk0 = n_chk;
    fork
      send_frame(1'b0, ok);
      begin
        n = 0;
        while (cur_bit != 20 && n < 30000) begin @(negedge hclk); n++; end
        check("t5_reach_bit20", cur_bit, 20);
        repeat (10) @(negedge hclk);
        rst_n = 1'b0;
        @(negedge hclk);
        rst_n = 1'b1;
        check("t5_oe", dht_oe, 0);
        check("t5_busy", busy, 0);
        check("t5_hum", humidity, 0);
        check("t5_temp", temperature, 0);
        exp_hum = 8'd0; exp_temp = 8'd0;
      end
    join
    check("t5_no_err", (n_to - to0) + (n_chk - chk0), 0);
    h = 8'($urandom_range(95, 5)); t = 8'($urandom_range(50, 0));
    gen_hi({h, 8'd1, t, 8'd2, 8'(h + t + 8'd3)});
    run_txn("t5b", 1'b0);

    // 6: two identical good frames, start-to-start period
    h = 8'($urandom_range(95, 5)); t = 8'($urandom_range(50, 0));
    gen_hi({h, 8'd0, t, 8'd0, 8'(h + t)});
    run_txn("t6a", 1'b1);
    run_txn("t6b", 1'b1);
    check("t6_dv_spacing", dv_last - dv_prev, PERIOD_CY);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
